// File: rtl/vector_property_monitor.sv
`default_nettype none
// ============================================================================
// Module   : vector_property_monitor
// Brief    : Multi-channel onehot/onehot0/popcount checker with sticky flags,
//            saturating counters, valid-edge detect and first-error capture.
//            Optional messages: define VECTOR_PROPERTY_MONITOR_DISPLAY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vector_property_monitor #(
   parameter  int CH        = 4,
   parameter  int W         = 8,
   parameter  int CNT_W     = 16,
   parameter  int POP_LIMIT = 2,
   localparam int CH_W      = (CH > 1) ? $clog2(CH) : 1,
   localparam int PC_W      = $clog2(W + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [CH-1:0]         i_valid,
   input  logic [CH*W-1:0]       i_data,
   input  logic [2*CH-1:0]       i_mode,
   input  logic                  i_clear,
   output logic [CH-1:0]         o_err_pulse,
   output logic [CH-1:0]         o_err_sticky,
   output logic [CH*CNT_W-1:0]   o_err_count,
   output logic [CH-1:0]         o_rise,
   output logic                  o_first_valid,
   output logic [CH_W-1:0]       o_first_ch,
   output logic [W-1:0]          o_first_data
);

   localparam logic [1:0] c_MODE_NONE    = 2'd0;
   localparam logic [1:0] c_MODE_ONEHOT  = 2'd1;
   localparam logic [1:0] c_MODE_ONEHOT0 = 2'd2;
   localparam logic [1:0] c_MODE_POP     = 2'd3;
   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

   function automatic logic [PC_W-1:0] popcount(input logic [W-1:0] v);
      logic [PC_W-1:0] n;
      n = '0;
      for (int i = 0; i < W; i++) n = n + PC_W'(v[i]);
      return n;
   endfunction

   logic [CH-1:0]    w_viol;
   logic [CH-1:0]    r_err_pulse;
   logic [CH-1:0]    r_err_sticky;
   logic [CNT_W-1:0] r_cnt [CH];
   logic [CH-1:0]    r_valid_q;
   logic [CH-1:0]    r_rise;
   logic             r_first_valid;
   logic [CH_W-1:0]  r_first_ch;
   logic [W-1:0]     r_first_data;
   logic [CH_W-1:0]  w_low_ch;
   logic [W-1:0]     w_low_data;

   for (genvar c = 0; c < CH; c++) begin : g_chan
      logic [PC_W-1:0] w_pc;
      logic            w_fail;

      always_comb begin
         w_pc   = popcount(i_data[c*W +: W]);
         w_fail = 1'b0;
         case (i_mode[2*c +: 2])
            c_MODE_NONE:    w_fail = 1'b0;
            c_MODE_ONEHOT:  w_fail = (w_pc != PC_W'(1));
            c_MODE_ONEHOT0: w_fail = (w_pc > PC_W'(1));
            c_MODE_POP:     w_fail = (32'(w_pc) > POP_LIMIT);
            default:        w_fail = 1'b0;
         endcase
      end

      assign w_viol[c] = i_valid[c] & w_fail;
      assign o_err_count[c*CNT_W +: CNT_W] = r_cnt[c];
   end

   // Descending scan so the lowest violating index is the final assignment.
   always_comb begin
      w_low_ch   = '0;
      w_low_data = '0;
      for (int c = CH - 1; c >= 0; c--) begin
         if (w_viol[c]) begin
            w_low_ch   = CH_W'(c);
            w_low_data = i_data[c*W +: W];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_err_pulse   <= '0;
         r_err_sticky  <= '0;
         r_valid_q     <= '0;
         r_rise        <= '0;
         r_first_valid <= 1'b0;
         r_first_ch    <= '0;
         r_first_data  <= '0;
         for (int c = 0; c < CH; c++) r_cnt[c] <= '0;
      end else begin
         r_err_pulse <= w_viol;
         r_valid_q   <= i_valid;
         r_rise      <= i_valid & ~r_valid_q;
         if (i_clear) begin
            r_err_sticky  <= '0;
            r_first_valid <= 1'b0;
            r_first_ch    <= '0;
            r_first_data  <= '0;
            for (int c = 0; c < CH; c++) r_cnt[c] <= '0;
         end else begin
            r_err_sticky <= r_err_sticky | w_viol;
            for (int c = 0; c < CH; c++) begin
               if (w_viol[c] && (r_cnt[c] != c_CNT_MAX)) r_cnt[c] <= r_cnt[c] + CNT_W'(1);
            end
            if (!r_first_valid && (|w_viol)) begin
               r_first_valid <= 1'b1;
               r_first_ch    <= w_low_ch;
               r_first_data  <= w_low_data;
            end
         end
      end
   end

   assign o_err_pulse   = r_err_pulse;
   assign o_err_sticky  = r_err_sticky;
   assign o_rise        = r_rise;
   assign o_first_valid = r_first_valid;
   assign o_first_ch    = r_first_ch;
   assign o_first_data  = r_first_data;

`ifdef VECTOR_PROPERTY_MONITOR_DISPLAY_EN
   logic [CH-1:0]     r_sat_warned;
   logic [CH*W-1:0]   r_msg_data;
   logic [2*CH-1:0]   r_msg_mode;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sat_warned <= '0;
         r_msg_data   <= '0;
         r_msg_mode   <= '0;
      end else begin
         r_msg_data <= i_data;
         r_msg_mode <= i_mode;
         for (int c = 0; c < CH; c++) begin
            if (r_err_pulse[c])
               $error("vector_property_monitor: ch %0d violation t=%0t mode=%0d data=0x%h",
                      c, $time, r_msg_mode[2*c +: 2], r_msg_data[c*W +: W]);
            if (i_clear)
               r_sat_warned[c] <= 1'b0;
            else if ((r_cnt[c] == c_CNT_MAX) && !r_sat_warned[c]) begin
               $warning("vector_property_monitor: ch %0d counter saturated t=%0t", c, $time);
               r_sat_warned[c] <= 1'b1;
            end
         end
      end
   end
`else
   // Silent build: no messages, identical register behaviour.
`endif

endmodule
`default_nettype wire

// File: tb/tb_vector_property_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_property_monitor
// Brief    : Directed plus randomized bench for vector_property_monitor,
//            checked against a spec-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_property_monitor;

   localparam int CH        = 4;
   localparam int W         = 8;
   localparam int CNT_W     = 3;
   localparam int POP_LIMIT = 2;
   localparam int CH_W      = 2;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [CH-1:0]        valid = '0;
   logic [CH*W-1:0]      data = '0;
   logic [2*CH-1:0]      mode = '0;
   logic                 clear = 1'b0;
   logic [CH-1:0]        err_pulse;
   logic [CH-1:0]        err_sticky;
   logic [CH*CNT_W-1:0]  err_count;
   logic [CH-1:0]        rise;
   logic                 first_valid;
   logic [CH_W-1:0]      first_ch;
   logic [W-1:0]         first_data;

   vector_property_monitor #(
      .CH(CH), .W(W), .CNT_W(CNT_W), .POP_LIMIT(POP_LIMIT)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_data(data),
      .i_mode(mode), .i_clear(clear), .o_err_pulse(err_pulse),
      .o_err_sticky(err_sticky), .o_err_count(err_count), .o_rise(rise),
      .o_first_valid(first_valid), .o_first_ch(first_ch), .o_first_data(first_data)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   logic [CH-1:0] m_pulse, m_sticky, m_rise, m_prev_valid;
   int            m_cnt [CH];
   logic          m_fv;
   int            m_fch;
   logic [W-1:0]  m_fdata;

   function automatic bit violates(input logic [1:0] md, input logic [W-1:0] v);
      int ones;
      ones = $countones(v);
      case (md)
         2'd1:    return ones != 1;
         2'd2:    return ones > 1;
         2'd3:    return ones > POP_LIMIT;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_pulse = '0; m_sticky = '0; m_rise = '0; m_prev_valid = '0;
      for (int c = 0; c < CH; c++) m_cnt[c] = 0;
      m_fv = 1'b0; m_fch = 0; m_fdata = '0;
   endtask

   task automatic model_edge();
      logic [CH-1:0] viol;
      int low;
      low = -1;
      for (int c = 0; c < CH; c++) begin
         viol[c] = valid[c] && violates(mode[2*c +: 2], data[c*W +: W]);
         if (viol[c] && low < 0) low = c;
      end
      m_pulse = viol;
      m_rise  = valid & ~m_prev_valid;
      m_prev_valid = valid;
      if (clear) begin
         m_sticky = '0;
         for (int c = 0; c < CH; c++) m_cnt[c] = 0;
         m_fv = 1'b0; m_fch = 0; m_fdata = '0;
      end else begin
         m_sticky = m_sticky | viol;
         for (int c = 0; c < CH; c++)
            if (viol[c] && m_cnt[c] < CNT_MAX) m_cnt[c] = m_cnt[c] + 1;
         if (!m_fv && low >= 0) begin
            m_fv = 1'b1; m_fch = low; m_fdata = data[low*W +: W];
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [CH*CNT_W-1:0] exp_cnt;
      for (int c = 0; c < CH; c++) exp_cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
      n_assert += 7;
      assert (err_pulse === m_pulse) else begin
         n_fail++; $error("FAIL %s pulse: observed %h expected %h", tag, err_pulse, m_pulse); end
      assert (err_sticky === m_sticky) else begin
         n_fail++; $error("FAIL %s sticky: observed %h expected %h", tag, err_sticky, m_sticky); end
      assert (err_count === exp_cnt) else begin
         n_fail++; $error("FAIL %s count: observed %h expected %h", tag, err_count, exp_cnt); end
      assert (rise === m_rise) else begin
         n_fail++; $error("FAIL %s rise: observed %h expected %h", tag, rise, m_rise); end
      assert (first_valid === m_fv) else begin
         n_fail++; $error("FAIL %s first_valid: observed %b expected %b", tag, first_valid, m_fv); end
      assert (first_ch === CH_W'(m_fch)) else begin
         n_fail++; $error("FAIL %s first_ch: observed %0d expected %0d", tag, first_ch, m_fch); end
      assert (first_data === m_fdata) else begin
         n_fail++; $error("FAIL %s first_data: observed %h expected %h", tag, first_data, m_fdata); end
   endtask

   task automatic step(input string tag, input logic [CH-1:0] v, input logic [CH*W-1:0] d,
                       input logic [2*CH-1:0] md, input logic clr);
      valid = v; data = d; mode = md; clear = clr;
      model_edge();
      @(posedge clk); #1;
      check_all(tag);
   endtask

   initial begin
      model_reset();
      // Reset held with all channels valid in onehot mode
      valid = 4'hF; mode = 8'h55; data = 32'h01010101;
      #3 check_all("reset_async");
      @(posedge clk); #1;
      check_all("reset_held");
      rst_n = 1'b1;
      step("rise_first", 4'hF, 32'h01010101, 8'h55, 1'b0);
      step("rise_gone",  4'hF, 32'h01010101, 8'h55, 1'b0);
      step("idle",       4'h0, 32'h0,        8'h01, 1'b1);

      // Onehot on ch0
      step("oh_viol",    4'h1, 32'h03, 8'h01, 1'b0);
      step("oh_ok",      4'h1, 32'h04, 8'h01, 1'b0);

      // Onehot0 on ch1 and ch3, simultaneous violation
      step("clr1",       4'h0, 32'h0, 8'h89, 1'b1);
      step("oh0_dual",   4'hA, 32'hFF00_8100, 8'h89, 1'b0);
      step("cap_hold",   4'h1, 32'h0000_0003, 8'h89, 1'b0);

      // Popcount limit on ch2
      step("pop_7",      4'h4, 32'h0007_0000, 8'hB9, 1'b0);
      step("pop_5",      4'h4, 32'h0005_0000, 8'hB9, 1'b0);
      step("pop_0",      4'h4, 32'h0000_0000, 8'hB9, 1'b0);

      // Counter saturation
      step("clr2",       4'h0, 32'h0, 8'h01, 1'b1);
      for (int i = 0; i < 10; i++) step("sat", 4'h1, 32'h03, 8'h01, 1'b0);
      step("sat_quiet",  4'h0, 32'h03, 8'h01, 1'b0);

      // Clear concurrent with violation
      step("clr_viol",   4'h1, 32'h03, 8'h01, 1'b1);
      step("after_clr",  4'h0, 32'h0,  8'h01, 1'b0);

      // Randomized traffic; data biased toward few set bits
      for (int i = 0; i < 400; i++) begin
         logic [CH*W-1:0] d;
         logic [2*CH-1:0] md;
         for (int c = 0; c < CH; c++) begin
            case ($urandom_range(0, 3))
               0:       d[c*W +: W] = '0;
               1:       d[c*W +: W] = W'(1) << $urandom_range(0, W - 1);
               2:       d[c*W +: W] = (W'(1) << $urandom_range(0, W - 1)) | (W'(1) << $urandom_range(0, W - 1));
               default: d[c*W +: W] = W'($urandom);
            endcase
         end
         md = (i % 25 == 0) ? 8'($urandom) : mode;
         step("rand", 4'($urandom), d, md, ($urandom_range(0, 19) == 0));
      end

      // Asynchronous reset mid-cycle
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_all("reset_mid");
      #10 rst_n = 1'b1;
      valid = '0; clear = 1'b0;
      step("post_reset", 4'h0, 32'h0, 8'h00, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
